// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered-timing outputs of the VGA sync decoder
interface vga_sync_decoder_if;
    logic        i_HSync;
    logic        i_VSync;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_valid;
    logic        o_locked;
    logic        o_err;
    logic [11:0] o_line_len;

    modport master (
        output i_HSync,
        output i_VSync,
        input  o_x,
        input  o_y,
        input  o_valid,
        input  o_locked,
        input  o_err,
        input  o_line_len
    );

    modport slave (
        input  i_HSync,
        input  i_VSync,
        output o_x,
        output o_y,
        output o_valid,
        output o_locked,
        output o_err,
        output o_line_len
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel position from raw VGA syncs and locks onto the expected timing
module vga_sync_decoder #(
    parameter int H_SYNC_WIDTH = 96,
    parameter int H_BACK_PORCH = 48,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_SYNC_WIDTH = 2,
    parameter int V_BACK_PORCH = 33,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525
) (
    input logic               i_Clk,
    input logic               i_Rst_n,
    vga_sync_decoder_if.slave bus
);

    localparam int H_START = H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int V_END   = V_START + V_ACTIVE;

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_t;

    state_t      state;
    logic        h_meta, h_sync, h_hist;
    logic        v_meta, v_sync, v_hist;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] line_len;
    logic        err;
    logic        sat_seen;

    logic        h_fall;
    logic        v_fall;
    logic        h_max;
    logic        v_max;
    logic [12:0] h_cnt_inc;
    logic [12:0] v_cnt_inc;

    assign h_fall    = ~h_sync & h_hist;
    assign v_fall    = ~v_sync & v_hist;
    assign h_max     = (h_cnt == 12'hFFF);
    assign v_max     = (v_cnt == 12'hFFF);
    assign h_cnt_inc = {1'b0, h_cnt} + 13'd1;
    assign v_cnt_inc = {1'b0, v_cnt} + 13'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            h_meta <= 1'b1;
            h_sync <= 1'b1;
            h_hist <= 1'b1;
            v_meta <= 1'b1;
            v_sync <= 1'b1;
            v_hist <= 1'b1;
        end else begin
            h_meta <= bus.i_HSync;
            h_sync <= h_meta;
            h_hist <= h_sync;
            v_meta <= bus.i_VSync;
            v_sync <= v_meta;
            v_hist <= v_sync;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            h_cnt    <= 12'd0;
            v_cnt    <= 12'd0;
            line_len <= 12'd0;
        end else begin
            if (h_fall) begin
                h_cnt    <= 12'd0;
                line_len <= h_max ? 12'hFFF : h_cnt_inc[11:0];
            end else if (!h_max) begin
                h_cnt <= h_cnt_inc[11:0];
            end

            if (v_fall) begin
                v_cnt <= 12'd0;
            end else if (h_fall && !v_max) begin
                v_cnt <= v_cnt_inc[11:0];
            end
        end
    end

    // A frame edge skips the line check: that h_fall closes the previous frame, not a measured line.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= SEARCH;
            err      <= 1'b0;
            sat_seen <= 1'b0;
        end else begin
            err <= 1'b0;
            if (h_fall) begin
                sat_seen <= 1'b0;
            end else if (h_max) begin
                sat_seen <= 1'b1;
            end

            case (state)
                SEARCH: begin
                    if (v_fall) begin
                        state <= CHECK;
                    end
                end
                CHECK, LOCKED: begin
                    if (v_fall) begin
                        if (v_cnt_inc != 13'(V_TOTAL)) begin
                            state <= SEARCH;
                            err   <= 1'b1;
                        end else begin
                            state <= LOCKED;
                        end
                    end else if (h_fall) begin
                        if (h_cnt_inc != 13'(H_TOTAL)) begin
                            state <= SEARCH;
                            err   <= 1'b1;
                        end
                    end else if (h_max && !sat_seen) begin
                        state <= SEARCH;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

    assign bus.o_x        = h_cnt - 12'(H_START);
    assign bus.o_y        = v_cnt - 12'(V_START);
    assign bus.o_locked   = (state == LOCKED);
    assign bus.o_err      = err;
    assign bus.o_line_len = line_len;
    assign bus.o_valid    = (state == LOCKED)
                          && ({1'b0, h_cnt} >= 13'(H_START)) && ({1'b0, h_cnt} < 13'(H_END))
                          && ({1'b0, v_cnt} >= 13'(V_START)) && ({1'b0, v_cnt} < 13'(V_END));

endmodule
